// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv_top execute core.
// Contents: datapath width, opcode and funct3 constants, the ALU operation
// enum, and immediate-extraction helpers used by the decoder.
package riscv_pkg;

  localparam int XLEN = 32;

  // Major opcodes handled by the core.
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // funct3 codes shared by the R-type and I-type ALU groups.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 values accepted on R-type and shift-immediate instructions.
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASSB
  } alu_op_e;

  // Sign-extended I-type immediate.
  function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] instr);
    return {{(XLEN-12){instr[31]}}, instr[31:20]};
  endfunction

  // U-type immediate: upper 20 bits, low 12 bits zero.
  function automatic logic [XLEN-1:0] imm_u(input logic [XLEN-1:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32-entry integer register file.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low clear of every entry
//   we             write enable (sampled on the rising edge)
//   waddr, wdata   write port
//   raddr1/rdata1  combinational read port 1
//   raddr2/rdata2  combinational read port 2
// x0 is never written and always reads as zero.
module riscv_regfile
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [4:0]       raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic [4:0]       raddr2,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] regs [32];

  // The asynchronous clear rules out block RAM; this maps to flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle rd == rs reads old data.
  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/riscv_top.sv
// Single-cycle RV32I integer execute core (R-type ALU, I-type ALU, LUI).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   addr  instruction word executed on the next rising edge
//   rd    destination index of the last retired instruction, 0 after a NOP
// Decode and ALU are combinational; the register file write and the rd
// register update on the same edge.
module riscv_top
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  output logic [4:0]       rd
);

  // Instruction fields.
  logic [6:0] opcode;
  logic [4:0] rd_field;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode   = addr[6:0];
  assign rd_field = addr[11:7];
  assign funct3   = addr[14:12];
  assign rs1      = addr[19:15];
  assign rs2      = addr[24:20];
  assign funct7   = addr[31:25];

  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic [4:0]       shamt;
  logic             valid;
  logic             f7_ok;
  alu_op_e          alu_op;
  logic [4:0]       rd_reg;

  assign f7_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);

  // Decode: select the ALU operation, operand B and whether to retire.
  always_comb begin
    valid  = 1'b0;
    alu_op = ALU_ADD;
    op_b   = rs2_val;
    unique case (opcode)
      OP_R: begin
        valid = f7_ok;
        unique case (funct3)
          F3_ADD:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
          F3_SLL:  alu_op = ALU_SLL;
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLTU: alu_op = ALU_SLTU;
          F3_XOR:  alu_op = ALU_XOR;
          F3_SR:   alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_I: begin
        op_b  = imm_i(addr);
        valid = 1'b1;
        unique case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_SLL: begin
            alu_op = ALU_SLL;
            valid  = f7_ok;
          end
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLTU: alu_op = ALU_SLTU;
          F3_XOR:  alu_op = ALU_XOR;
          F3_SR: begin
            // imm[10] (instruction bit 30) distinguishes SRAI from SRLI.
            alu_op = addr[30] ? ALU_SRA : ALU_SRL;
            valid  = f7_ok;
          end
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_LUI: begin
        valid  = 1'b1;
        alu_op = ALU_PASSB;
        op_b   = imm_u(addr);
      end
      default: valid = 1'b0;
    endcase
  end

  assign op_a  = rs1_val;
  assign shamt = op_b[4:0];

  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_ADD:   result = op_a + op_b;
      ALU_SUB:   result = op_a - op_b;
      ALU_SLL:   result = op_a << shamt;
      ALU_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:   result = op_a ^ op_b;
      ALU_SRL:   result = op_a >> shamt;
      ALU_SRA:   result = $signed(op_a) >>> shamt;
      ALU_OR:    result = op_a | op_b;
      ALU_AND:   result = op_a & op_b;
      ALU_PASSB: result = op_b;
      default:   result = '0;
    endcase
  end

  riscv_regfile #(
    .WIDTH(WIDTH)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (valid),
    .waddr  (rd_field),
    .wdata  (result),
    .raddr1 (rs1),
    .rdata1 (rs1_val),
    .raddr2 (rs2),
    .rdata2 (rs2_val)
  );

  // A write to x0 still reports index 0, which is also the NOP value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_reg <= 5'd0;
    end else begin
      rd_reg <= valid ? rd_field : 5'd0;
    end
  end

  assign rd = rd_reg;

endmodule

// File: tb/tb_riscv_top.sv
module tb_riscv_top;
  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [4:0]  rd;

  int total;
  int bad;

  riscv_top #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .rd   (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  exp_rd;
    int          idx;
    logic [31:0] exp_val;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  exp_rd;
    int          idx;
    logic [31:0] exp_val;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rdx);
    return {f7, rs2, rs1, f3, rdx, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rdx);
    return {imm, rs1, f3, rdx, 7'b0010011};
  endfunction

  function automatic logic [31:0] reg_at(input int i);
    return dut.u_regfile.regs[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [31:0] i, input logic [4:0] r,
                              input int x, input logic [31:0] v);
    vec_t t;
    t.name = n; t.instr = i; t.exp_rd = r; t.idx = x; t.exp_val = v;
    return t;
  endfunction

  // Drive one instruction, queue its expectation, check after the edge.
  task automatic run_one(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    addr = v.instr;
    e.name = v.name; e.exp_rd = v.exp_rd; e.idx = v.idx; e.exp_val = v.exp_val;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      got = sb.pop_front();
      check({got.name, "_rd"}, {27'd0, rd}, {27'd0, got.exp_rd});
      check({got.name, "_reg"}, reg_at(got.idx), got.exp_val);
      $display("txn %-10s instr=0x%08h rd=%0d x%0d=0x%08h", got.name, v.instr, rd,
               got.idx, reg_at(got.idx));
    end
  endtask

  logic [31:0] snap [32];
  int diffs;

  initial begin
    total = 0;
    bad   = 0;
    addr  = 32'h0050_0313;
    rst   = 1'b1;
    #1 rst = 1'b0;

    // Reset held across edges with a valid ADDI on the bus: nothing written.
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd", {27'd0, rd}, 32'd0);
    diffs = 0;
    for (int i = 0; i < 32; i++) if (reg_at(i) !== 32'd0) diffs++;
    check("reset_regs_nonzero", diffs, 0);
    $display("txn reset     rd=%0d nonzero_regs=%0d", rd, diffs);
    @(negedge clk);
    rst = 1'b1;

    vecs.push_back(mk("add_x0",   32'h0073_0033, 5'd0,  0,  32'h0));
    vecs.push_back(mk("addi_x6",  32'h0050_0313, 5'd6,  6,  32'd5));
    vecs.push_back(mk("addi_x7",  32'hFFD0_0393, 5'd7,  7,  32'hFFFF_FFFD));
    vecs.push_back(mk("add_x5",   32'h0073_02B3, 5'd5,  5,  32'd2));
    vecs.push_back(mk("sub_x8",   32'h4073_0433, 5'd8,  8,  32'd8));
    vecs.push_back(mk("srai_x9",  32'h4013_D493, 5'd9,  9,  32'hFFFF_FFFE));
    vecs.push_back(mk("slt",      enc_r(7'h00, 5'd6, 5'd7, 3'b010, 5'd10), 5'd10, 10, 32'd1));
    vecs.push_back(mk("sltu",     enc_r(7'h00, 5'd6, 5'd7, 3'b011, 5'd11), 5'd11, 11, 32'd0));
    vecs.push_back(mk("xor",      enc_r(7'h00, 5'd7, 5'd6, 3'b100, 5'd12), 5'd12, 12, 32'hFFFF_FFF8));
    vecs.push_back(mk("or",       enc_r(7'h00, 5'd7, 5'd6, 3'b110, 5'd13), 5'd13, 13, 32'hFFFF_FFFD));
    vecs.push_back(mk("and",      enc_r(7'h00, 5'd7, 5'd6, 3'b111, 5'd14), 5'd14, 14, 32'd5));
    vecs.push_back(mk("sll",      enc_r(7'h00, 5'd6, 5'd6, 3'b001, 5'd15), 5'd15, 15, 32'h0000_00A0));
    vecs.push_back(mk("srl",      enc_r(7'h00, 5'd6, 5'd7, 3'b101, 5'd16), 5'd16, 16, 32'h07FF_FFFF));
    vecs.push_back(mk("sra",      enc_r(7'h20, 5'd6, 5'd7, 3'b101, 5'd17), 5'd17, 17, 32'hFFFF_FFFF));
    vecs.push_back(mk("lui",      32'h1234_5937, 5'd18, 18, 32'h1234_5000));
    vecs.push_back(mk("slti",     enc_i(12'hFFE, 5'd7, 3'b010, 5'd19), 5'd19, 19, 32'd1));
    vecs.push_back(mk("sltiu",    enc_i(12'hFFF, 5'd6, 3'b011, 5'd20), 5'd20, 20, 32'd1));
    vecs.push_back(mk("xori",     enc_i(12'h00F, 5'd6, 3'b100, 5'd21), 5'd21, 21, 32'd10));
    vecs.push_back(mk("ori",      enc_i(12'h00A, 5'd6, 3'b110, 5'd22), 5'd22, 22, 32'd15));
    vecs.push_back(mk("andi",     enc_i(12'h0FF, 5'd7, 3'b111, 5'd23), 5'd23, 23, 32'h0000_00FD));
    vecs.push_back(mk("slli",     enc_i(12'h003, 5'd6, 3'b001, 5'd24), 5'd24, 24, 32'd40));
    vecs.push_back(mk("srli",     enc_i(12'h01C, 5'd7, 3'b101, 5'd25), 5'd25, 25, 32'h0000_000F));
    vecs.push_back(mk("add_same", enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd5), 5'd5, 5, 32'd4));
    vecs.push_back(mk("lui_min",  32'h8000_0DB7, 5'd27, 27, 32'h8000_0000));
    vecs.push_back(mk("add_wrap", enc_r(7'h00, 5'd27, 5'd27, 3'b000, 5'd28), 5'd28, 28, 32'd0));
    vecs.push_back(mk("sub_neg",  enc_r(7'h20, 5'd6, 5'd0, 3'b000, 5'd29), 5'd29, 29, 32'hFFFF_FFFB));
    vecs.push_back(mk("addi_x0",  enc_i(12'h001, 5'd6, 3'b000, 5'd0), 5'd0, 0, 32'd0));
    vecs.push_back(mk("rebuild",  enc_r(7'h00, 5'd0, 5'd6, 3'b000, 5'd5), 5'd5, 5, 32'd5));
    vecs.push_back(mk("bad_f7",   enc_r(7'h01, 5'd7, 5'd6, 3'b000, 5'd30), 5'd0, 30, 32'd0));
    vecs.push_back(mk("bad_slli", enc_i(12'h023, 5'd6, 3'b001, 5'd31), 5'd0, 31, 32'd0));

    foreach (vecs[k]) run_one(vecs[k]);

    // x5 was rebuilt to 5 so it is nonzero for the reset check below.
    // Unsupported opcode after a retiring instruction: rd drops, no register moves.
    run_one(mk("pre_nop", 32'h0050_0313, 5'd6, 6, 32'd5));
    for (int i = 0; i < 32; i++) snap[i] = reg_at(i);
    run_one(mk("nop_zero", 32'h0000_0000, 5'd0, 6, 32'd5));
    diffs = 0;
    for (int i = 0; i < 32; i++) if (reg_at(i) !== snap[i]) diffs++;
    check("nop_regs_changed", diffs, 0);
    $display("txn nop_all   changed_regs=%0d", diffs);

    // Asynchronous reset between edges: takes effect before the next edge.
    run_one(mk("pre_rst", enc_i(12'h009, 5'd0, 3'b000, 5'd9), 5'd9, 9, 32'd9));
    @(negedge clk);
    addr = 32'h0050_0313;
    #2 rst = 1'b0;
    #1;
    check("midrst_rd", {27'd0, rd}, 32'd0);
    diffs = 0;
    for (int i = 5; i <= 9; i++) if (reg_at(i) !== 32'd0) diffs++;
    check("midrst_regs_nonzero", diffs, 0);
    $display("txn mid_rst   rd=%0d nonzero_x5_x9=%0d", rd, diffs);

    // Edge while reset is held: the ADDI on the bus must not land.
    @(posedge clk);
    #1;
    check("rst_edge_x6", reg_at(6), 32'd0);
    check("rst_edge_rd", {27'd0, rd}, 32'd0);
    $display("txn rst_edge  rd=%0d x6=0x%08h", rd, reg_at(6));
    @(negedge clk);
    rst = 1'b1;
    run_one(mk("post_rst", 32'h0050_0313, 5'd6, 6, 32'd5));

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_top.md
Name: riscv_top

Overview:
- Minimal single-cycle RV32I integer execute core.
- Accepts one 32-bit instruction word per clock on `addr`, decodes it, reads two operands from an internal 32-entry register file, computes the ALU result and writes it back on the same rising edge.
- Top level of the small CPU datapath; instruction fetch and PC are external.
- Only observable port output: destination-register index of the last retired instruction.

Parameters:
- WIDTH, 32: datapath, register and instruction-bus width. Only 32 is supported; instruction fields decode from bits 31:0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- addr  input  WIDTH  instruction word to execute this cycle.
- rd  output  5  registered destination index of the last retired writeback instruction; 0 otherwise.

Behaviour:
- Reset: rst=0 immediately forces rd=0 and clears all 32 registers to 0, independent of clk. Reset asserted mid-operation aborts any write on that edge.
- Timing: each posedge with rst=1 executes the instruction present on addr. One-cycle latency: register write and rd update occur at that edge. Back-to-back dependent instructions work, because reads are combinational from the current register contents.
- Decode fields: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- Immediates:
  - I-imm = sign-extended [31:20].
  - U-imm = {[31:12], 12'b0}.
- Supported instructions:
  - R-type (0110011): ADD/SUB (funct7[5] selects SUB), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]), OR, AND.
  - I-type (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI (imm[10] selects SRAI).
  - LUI (0110111): writes U-imm.
- Arithmetic rules:
  - Add/sub wrap modulo 2^32.
  - Shift amount = low 5 bits of operand B.
  - SLT is signed, SLTU unsigned; both produce 0 or 1.
- Writeback: on a supported instruction, reg[rd] <= result and output rd <= rd field.
- x0: reads always return 0; writes to x0 are discarded, but output rd still shows 0 (the field value).
- Unsupported opcode or invalid funct7 (R-type funct7 not 0x00/0x20; shift-immediate upper bits other than 0x00/0x20): treated as NOP. No register write, output rd <= 0.
- Same-register source and destination (e.g. ADD x5,x5,x5): read the old value, write the new one.

Decomposition:
- Package riscv_pkg:
  - opcode constants (OP_R, OP_I, OP_LUI);
  - funct3 codes;
  - an ALU operation enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB).
- Sub-module riscv_regfile, instantiated as u_regfile:
  - 32 x WIDTH array named regs;
  - two asynchronous read ports and one synchronous write port;
  - async active-low clear;
  - x0 hardwired to 0.
- Decode and ALU stay in the top level.
- The bench inspects state via u_regfile.regs[n].

Test Plan:
- Reset: hold rst=0 across edges, addr=0x00500313 -> rd=0 and all regs 0; no write occurs.
- Writeback to x0: rst=1, addr=0x00730033 (ADD x0,x6,x7) -> after the edge rd=0 and regs[0]=0.
- Immediate and register ops:
  - ADDI x6,x0,5 (0x00500313) -> regs[6]=5, rd=6.
  - ADDI x7,x0,-3 (0xFFD00393) -> regs[7]=0xFFFFFFFD, rd=7.
  - ADD x5,x6,x7 (0x007302B3) -> regs[5]=2, rd=5.
- SUB and arithmetic shift:
  - SUB x8,x6,x7 (0x40730433) -> regs[8]=8.
  - SRAI x9,x7,1 (0x4013D493) -> regs[9]=0xFFFFFFFE, rd=9.
- Unsupported opcode: addr=0x00000000 -> rd=0, every register unchanged.
- Reset mid-run: after the above, drop rst to 0 between edges -> rd=0 and regs[5..9]=0 immediately, before the next clk edge.
